// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core: operand forwarding from MEM/WB,
// load-use stall detection, and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    // decode
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       id_imm,
    // register file read data (registered on the same edge as this stage)
    input  logic [31:0]       rf_data1,
    input  logic [31:0]       rf_data2,
    input  logic              flush,
    // MEM stage
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [4:0]        mem_rd,
    input  logic [31:0]       mem_result,
    // WB stage
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    // EX stage
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_imm,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic              id_stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              ex_valid_q, ex_reg_write_q, ex_mem_read_q, ex_mem_write_q;
    logic [4:0]        ex_rs_q, ex_rt_q, ex_rd_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [31:0]       ex_imm_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              rs_hit, rt_hit;
    logic              load_bubble;

    // MEM outranks WB as the younger producer; a load in MEM has no data yet.
    function automatic logic [31:0] fwd_operand(
        input logic [4:0]  src,
        input logic [31:0] rf_val,
        input logic        m_we,
        input logic        m_load,
        input logic [4:0]  m_rd,
        input logic [31:0] m_val,
        input logic        w_we,
        input logic [4:0]  w_rd,
        input logic [31:0] w_val
    );
        logic [31:0] res;
        res = rf_val;
        if (src == 5'd0) begin
            res = '0;
        end else if (m_we && !m_load && (m_rd == src)) begin
            res = m_val;
        end else if (w_we && (w_rd == src)) begin
            res = w_val;
        end
        return res;
    endfunction

    always_comb begin
        rs_hit   = id_uses_rs && (id_rs == ex_rd_q);
        rt_hit   = id_uses_rt && (id_rt == ex_rd_q);
        id_stall = ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) &&
                   id_valid && !flush && (rs_hit || rt_hit);
    end

    always_comb begin
        ex_op1 = fwd_operand(ex_rs_q, rf_data1, mem_reg_write, mem_mem_read, mem_rd,
                             mem_result, wb_reg_write, wb_rd, wb_data);
        ex_op2 = fwd_operand(ex_rt_q, rf_data2, mem_reg_write, mem_mem_read, mem_rd,
                             mem_result, wb_reg_write, wb_rd, wb_data);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (id_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && id_valid && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    assign load_bubble = flush || id_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd_q        <= '0;
            ex_ctrl_q      <= '0;
            ex_imm_q       <= '0;
        end else if (load_bubble) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd_q        <= '0;
            ex_ctrl_q      <= '0;
            ex_imm_q       <= '0;
        end else begin
            ex_valid_q     <= id_valid;
            ex_reg_write_q <= id_reg_write;
            ex_mem_read_q  <= id_mem_read;
            ex_mem_write_q <= id_mem_write;
            ex_rs_q        <= id_rs;
            ex_rt_q        <= id_rt;
            ex_rd_q        <= id_rd;
            ex_ctrl_q      <= id_ctrl;
            ex_imm_q       <= id_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_mem_write = ex_mem_write_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_rd        = ex_rd_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign ex_imm       = ex_imm_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver applies directed and random decode/forwarding
// traffic and queues the reference model's expectation; a negedge monitor compares.
module tb_id_ex_stage;

    localparam int unsigned CW   = 8;
    localparam int unsigned NW   = 6;
    localparam int unsigned CMAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_rs, id_uses_rt;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          id_reg_write, id_mem_read, id_mem_write;
    logic [CW-1:0] id_ctrl;
    logic [31:0]   id_imm, rf_data1, rf_data2;
    logic          flush;
    logic          mem_reg_write, mem_mem_read;
    logic [4:0]    mem_rd;
    logic [31:0]   mem_result;
    logic          wb_reg_write;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [CW-1:0] ex_ctrl;
    logic [31:0]   ex_imm, ex_op1, ex_op2;
    logic          id_stall;
    logic [NW-1:0] stall_cnt, flush_cnt;

    id_ex_stage #(.CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_ctrl(id_ctrl), .id_imm(id_imm), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .flush(flush), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_rd(mem_rd), .mem_result(mem_result), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_imm(ex_imm), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .id_stall(id_stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Instruction currently held in EX (model view).
    typedef struct {
        logic          valid, rw, mr, mw;
        logic [4:0]    rs, rt, rd;
        logic [CW-1:0] ctrl;
        logic [31:0]   imm;
    } instr_t;

    typedef struct {
        instr_t      ex;
        logic [31:0] op1, op2;
        logic        stall;
        int unsigned scnt, fcnt;
    } exp_t;

    instr_t      m_ex;
    int unsigned m_scnt, m_fcnt;
    exp_t        exp_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    function automatic instr_t bubble();
        instr_t b;
        b.valid = 1'b0; b.rw = 1'b0; b.mr = 1'b0; b.mw = 1'b0;
        b.rs = '0; b.rt = '0; b.rd = '0; b.ctrl = '0; b.imm = '0;
        return b;
    endfunction

    // Value of architectural register r as seen by EX: youngest pending producer wins.
    function automatic logic [31:0] model_operand(input logic [4:0] r, input logic [31:0] rf);
        logic [4:0]  prd[$];
        logic [31:0] pval[$];
        if (r == 5'd0) return 32'd0;
        if (mem_reg_write && !mem_mem_read) begin
            prd.push_back(mem_rd);
            pval.push_back(mem_result);
        end
        if (wb_reg_write) begin
            prd.push_back(wb_rd);
            pval.push_back(wb_data);
        end
        for (int i = 0; i < prd.size(); i++) begin
            if (prd[i] == r) return pval[i];
        end
        return rf;
    endfunction

    function automatic logic model_stall();
        logic dep;
        dep = (id_uses_rs && id_rs == m_ex.rd) || (id_uses_rt && id_rt == m_ex.rd);
        return m_ex.valid && m_ex.mr && (m_ex.rd != 5'd0) && id_valid && !flush && dep;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        e.ex    = m_ex;
        e.op1   = model_operand(m_ex.rs, rf_data1);
        e.op2   = model_operand(m_ex.rt, rf_data2);
        e.stall = rst ? 1'b0 : model_stall();
        e.scnt  = m_scnt;
        e.fcnt  = m_fcnt;
        return e;
    endfunction

    task automatic model_edge();
        logic st;
        st = model_stall();
        if (st && m_scnt < CMAX) m_scnt++;
        if (flush && id_valid && m_fcnt < CMAX) m_fcnt++;
        if (flush || st) begin
            m_ex = bubble();
        end else begin
            m_ex.valid = id_valid; m_ex.rw = id_reg_write; m_ex.mr = id_mem_read;
            m_ex.mw = id_mem_write; m_ex.rs = id_rs; m_ex.rt = id_rt; m_ex.rd = id_rd;
            m_ex.ctrl = id_ctrl; m_ex.imm = id_imm;
        end
    endtask

    task automatic quiet();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_ctrl = '0; id_imm = '0; rf_data1 = '0; rf_data2 = '0; flush = 1'b0;
        mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = '0; mem_result = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                          input logic urt, input logic [4:0] rd, input logic load);
        id_valid = 1'b1; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_rd = rd; id_reg_write = 1'b1; id_mem_read = load; id_mem_write = 1'b0;
        id_ctrl = CW'($urandom); id_imm = $urandom;
    endtask

    // Queue this window's expectation, then take one clock edge.
    task automatic cycle();
        exp_q.push_back(model_expect());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_ex = bubble();
        m_scnt = 0;
        m_fcnt = 0;
        exp_q.push_back(model_expect());
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic randomize_inputs();
        id_valid      = ($urandom_range(0, 7) != 0);
        id_rs         = 5'($urandom_range(0, 7));
        id_rt         = 5'($urandom_range(0, 7));
        id_uses_rs    = 1'($urandom_range(0, 1));
        id_uses_rt    = 1'($urandom_range(0, 1));
        id_rd         = 5'($urandom_range(0, 7));
        id_reg_write  = 1'($urandom_range(0, 1));
        id_mem_read   = ($urandom_range(0, 2) == 0);
        id_mem_write  = 1'($urandom_range(0, 1));
        id_ctrl       = CW'($urandom);
        id_imm        = $urandom;
        rf_data1      = $urandom;
        rf_data2      = $urandom;
        flush         = ($urandom_range(0, 9) == 0);
        mem_reg_write = 1'($urandom_range(0, 1));
        mem_mem_read  = ($urandom_range(0, 3) == 0);
        mem_rd        = 5'($urandom_range(0, 7));
        mem_result    = $urandom;
        wb_reg_write  = 1'($urandom_range(0, 1));
        wb_rd         = 5'($urandom_range(0, 7));
        wb_data       = $urandom;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: one expectation per clock window, sampled at the negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ex_valid",     32'(ex_valid),     32'(e.ex.valid));
                chk("ex_reg_write", 32'(ex_reg_write), 32'(e.ex.rw));
                chk("ex_mem_read",  32'(ex_mem_read),  32'(e.ex.mr));
                chk("ex_mem_write", 32'(ex_mem_write), 32'(e.ex.mw));
                chk("ex_rs",        32'(ex_rs),        32'(e.ex.rs));
                chk("ex_rt",        32'(ex_rt),        32'(e.ex.rt));
                chk("ex_rd",        32'(ex_rd),        32'(e.ex.rd));
                chk("ex_ctrl",      32'(ex_ctrl),      32'(e.ex.ctrl));
                chk("ex_imm",       ex_imm,            e.ex.imm);
                chk("ex_op1",       ex_op1,            e.op1);
                chk("ex_op2",       ex_op2,            e.op2);
                chk("id_stall",     32'(id_stall),     32'(e.stall));
                chk("stall_cnt",    32'(stall_cnt),    e.scnt);
                chk("flush_cnt",    32'(flush_cnt),    e.fcnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        quiet();
        rst = 1'b1;
        #2;
        do_reset();

        // Back-to-back ALU RAW through MEM.
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b0); cycle();
        set_id(5'd8, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0); cycle();
        quiet();
        mem_reg_write = 1'b1; mem_rd = 5'd8; mem_result = 32'h0000_1234; rf_data1 = 32'h0;
        cycle();

        // MEM vs WB on the same register, then WB alone.
        set_id(5'd5, 1'b1, 5'd9, 1'b1, 5'd6, 1'b0); cycle();
        mem_reg_write = 1'b1; mem_rd = 5'd9; mem_result = 32'hAAAA_AAAA;
        wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 32'h5555_5555; rf_data2 = 32'h1111_1111;
        cycle();
        mem_reg_write = 1'b0;
        cycle();

        // Load-use: one stall, bubble, then WB supplies the load data.
        quiet();
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1); cycle();
        set_id(5'd10, 1'b1, 5'd2, 1'b0, 5'd11, 1'b0);
        cycle();
        cycle();
        id_valid = 1'b0;
        mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd10; mem_result = 32'h0BAD_0BAD;
        wb_reg_write = 1'b1; wb_rd = 5'd10; wb_data = 32'hDEAD_BEEF; rf_data1 = 32'h0;
        cycle();

        // Register zero is never forwarded.
        quiet();
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b0); cycle();
        mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hFFFF_FFFF; rf_data1 = 32'h1;
        rf_data2 = 32'h1;
        cycle();

        // Flush coincident with a load-use hazard.
        quiet();
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1); cycle();
        set_id(5'd12, 1'b1, 5'd12, 1'b1, 5'd13, 1'b0); flush = 1'b1;
        cycle();
        flush = 1'b0; id_valid = 1'b0;
        cycle();

        // Mid-stream asynchronous reset.
        set_id(5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1); cycle();
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            cycle();
            if (n == 200) do_reset();
        end

        // Drive the stall counter past saturation.
        quiet();
        for (int k = 0; k < int'(CMAX) + 6; k++) begin
            set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1); cycle();
            set_id(5'd0, 1'b0, 5'd7, 1'b1, 5'd2, 1'b0); cycle();
            cycle();
        end
        quiet();
        cycle();

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
